mpsoc_multi_timer: RTL and testbench

Parametrised multi-channel interval timer for the MPSoC Avalon-MM peripheral fabric. It generalises the single 16-bit-bus interval timer to NUM_CH independent down-counters of CNT_W bits on a 32-bit bus. Each channel adds a per-channel prescaler, a set-priority timeout flag and an optional PWM compare output. Per-channel interrupts are exposed individually and OR-reduced onto one processor IRQ line.

---
 rtl/mpsoc_timer_pkg.sv | 32 +++
 rtl/mpsoc_timer_channel.sv | 140 ++++++++++++++
 rtl/mpsoc_multi_timer.sv | 128 ++++++++++++
 tb/tb_mpsoc_multi_timer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mpsoc_timer_pkg.sv
// mpsoc_timer_pkg
// Shared definitions for the multi-channel interval timer:
//   - per-channel register offsets (word address bits [2:0])
//   - STATUS / CONTROL bit positions
//   - chan_wr_t: decoded one-hot write strobes for a single channel
package mpsoc_timer_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_PRESCALE = 3'd3;
    localparam logic [2:0] REG_SNAP     = 3'd4;
    localparam logic [2:0] REG_COMPARE  = 3'd5;

    localparam int STATUS_TO  = 0;
    localparam int STATUS_RUN = 1;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef struct packed {
        logic status;
        logic control;
        logic period;
        logic prescale;
        logic snap;
        logic compare;
    } chan_wr_t;

endpackage

// File: rtl/mpsoc_timer_channel.sv
// mpsoc_timer_channel
// One interval-timer channel: prescaler, down-counter, RUN/TO flags,
// snapshot register and (optionally) a PWM compare output.
// Optional feature macro: TIMER_PWM_EN (COMPARE register + registered PWM).
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   wr             decoded write strobes for this channel
//   writedata      bus write data
//   to_flag, run   STATUS bits
//   ito, cont      stored CONTROL bits
//   period, prescale, snap, compare   register values for readback
//   irq            TO & ITO (combinational)
//   pwm            registered PWM output
module mpsoc_timer_channel
    import mpsoc_timer_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int PRE_W      = 16,
    parameter int PERIOD_RST = 49999
)(
    input  logic             clk,
    input  logic             reset_n,
    input  chan_wr_t         wr,
    input  logic [31:0]      writedata,
    output logic             to_flag,
    output logic             run,
    output logic             ito,
    output logic             cont,
    output logic [CNT_W-1:0] period,
    output logic [PRE_W-1:0] prescale,
    output logic [CNT_W-1:0] snap,
    output logic [CNT_W-1:0] compare,
    output logic             irq,
    output logic             pwm
);

    logic [CNT_W-1:0] counter;
    logic [PRE_W-1:0] prescaler;
    logic             reload_pending;
    logic             timeout_pulse;
    logic             tick;
    logic             unused_wd;

    // Only some writedata bits matter for narrow parameterisations.
    assign unused_wd = ^writedata;

    assign tick = run && (prescaler == '0);
    assign irq  = to_flag & ito;

    // A PERIOD write is applied to the counter one cycle later, so the
    // reload always sees the freshly written PERIOD value.
    // timeout_pulse is registered on the reload edge; TO follows a cycle
    // later, and a coincident STATUS write loses so no event is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter        <= CNT_W'(PERIOD_RST);
            period         <= CNT_W'(PERIOD_RST);
            prescaler      <= '0;
            prescale       <= '0;
            snap           <= '0;
            run            <= 1'b0;
            to_flag        <= 1'b0;
            ito            <= 1'b0;
            cont           <= 1'b0;
            reload_pending <= 1'b0;
            timeout_pulse  <= 1'b0;
        end else begin
            if (wr.control) begin
                ito  <= writedata[CTRL_ITO];
                cont <= writedata[CTRL_CONT];
            end
            if (wr.period) begin
                period <= writedata[CNT_W-1:0];
            end
            if (wr.prescale) begin
                prescale <= writedata[PRE_W-1:0];
            end
            if (wr.snap) begin
                snap <= counter;
            end

            reload_pending <= wr.period;
            timeout_pulse  <= 1'b0;

            if (reload_pending) begin
                counter   <= period;
                prescaler <= prescale;
            end else if (run) begin
                if (prescaler == '0) begin
                    prescaler <= prescale;
                    if (counter != '0) begin
                        counter <= counter - CNT_W'(1);
                    end else begin
                        counter       <= period;
                        timeout_pulse <= 1'b1;
                    end
                end else begin
                    prescaler <= prescaler - PRE_W'(1);
                end
            end

            // Explicit START/STOP from software overrides automatic clears.
            if (wr.control && writedata[CTRL_START]) begin
                run <= 1'b1;
            end else if (wr.control && writedata[CTRL_STOP]) begin
                run <= 1'b0;
            end else if (reload_pending) begin
                run <= 1'b0;
            end else if (tick && (counter == '0) && !cont) begin
                run <= 1'b0;
            end

            if (timeout_pulse) begin
                to_flag <= 1'b1;
            end else if (wr.status) begin
                to_flag <= 1'b0;
            end
        end
    end

`ifdef TIMER_PWM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            compare <= '0;
            pwm     <= 1'b0;
        end else begin
            if (wr.compare) begin
                compare <= writedata[CNT_W-1:0];
            end
            pwm <= run && (counter < compare);
        end
    end
`else
    logic unused_cmp;
    assign unused_cmp = wr.compare;
    assign compare    = '0;
    assign pwm        = 1'b0;
`endif

endmodule

// File: rtl/mpsoc_multi_timer.sv
// mpsoc_multi_timer
// NUM_CH-channel interval timer on a 32-bit Avalon-MM slave.
// Word address = {channel, reg[2:0]}; channels >= NUM_CH read 0 and
// ignore writes. Optional macro TIMER_PWM_EN enables COMPARE/PWM.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata        slave write/address inputs
//   readdata                  registered read data (1-cycle latency)
//   irq                       OR of irq_vec
//   irq_vec                   per-channel TO & ITO
//   pwm_out                   per-channel PWM
module mpsoc_multi_timer
    import mpsoc_timer_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int PRE_W      = 16,
    parameter int PERIOD_RST = 49999
)(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [3+$clog2(NUM_CH)-1:0]  address,
    input  logic                         chipselect,
    input  logic                         write_n,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    output logic                         irq,
    output logic [NUM_CH-1:0]            irq_vec,
    output logic [NUM_CH-1:0]            pwm_out
);

    logic [3:0]  ch_idx;
    logic [2:0]  reg_off;
    logic        ch_valid;
    logic        wr_en;
    logic [31:0] rd_mux;

    logic [NUM_CH-1:0] to_vec;
    logic [NUM_CH-1:0] run_vec;
    logic [NUM_CH-1:0] ito_vec;
    logic [NUM_CH-1:0] cont_vec;
    logic [CNT_W-1:0]  period_arr   [NUM_CH];
    logic [PRE_W-1:0]  prescale_arr [NUM_CH];
    logic [CNT_W-1:0]  snap_arr     [NUM_CH];
    logic [CNT_W-1:0]  compare_arr  [NUM_CH];

    // With NUM_CH=1 the channel field has zero width and the shift yields 0.
    assign ch_idx   = 4'(address >> 3);
    assign reg_off  = address[2:0];
    assign ch_valid = (ch_idx < 4'(NUM_CH));
    assign wr_en    = chipselect && !write_n && ch_valid;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        chan_wr_t wr;

        always_comb begin
            wr = '0;
            if (wr_en && (ch_idx == 4'(i))) begin
                case (reg_off)
                    REG_STATUS:   wr.status   = 1'b1;
                    REG_CONTROL:  wr.control  = 1'b1;
                    REG_PERIOD:   wr.period   = 1'b1;
                    REG_PRESCALE: wr.prescale = 1'b1;
                    REG_SNAP:     wr.snap     = 1'b1;
                    REG_COMPARE:  wr.compare  = 1'b1;
                    default:      ;
                endcase
            end
        end

        mpsoc_timer_channel #(
            .CNT_W      (CNT_W),
            .PRE_W      (PRE_W),
            .PERIOD_RST (PERIOD_RST)
        ) u_channel (
            .clk       (clk),
            .reset_n   (reset_n),
            .wr        (wr),
            .writedata (writedata),
            .to_flag   (to_vec[i]),
            .run       (run_vec[i]),
            .ito       (ito_vec[i]),
            .cont      (cont_vec[i]),
            .period    (period_arr[i]),
            .prescale  (prescale_arr[i]),
            .snap      (snap_arr[i]),
            .compare   (compare_arr[i]),
            .irq       (irq_vec[i]),
            .pwm       (pwm_out[i])
        );
    end

    // Out-of-range channel indices match no iteration and read 0.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == 4'(c)) begin
                case (reg_off)
                    REG_STATUS: begin
                        rd_mux[STATUS_TO]  = to_vec[c];
                        rd_mux[STATUS_RUN] = run_vec[c];
                    end
                    REG_CONTROL: begin
                        rd_mux[CTRL_ITO]  = ito_vec[c];
                        rd_mux[CTRL_CONT] = cont_vec[c];
                    end
                    REG_PERIOD:   rd_mux = 32'(period_arr[c]);
                    REG_PRESCALE: rd_mux = 32'(prescale_arr[c]);
                    REG_SNAP:     rd_mux = 32'(snap_arr[c]);
                    REG_COMPARE:  rd_mux = 32'(compare_arr[c]);
                    default:      rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_mpsoc_multi_timer.sv
// tb_mpsoc_multi_timer
// Self-checking bench for mpsoc_multi_timer (default parameters).
// Expected values are queued when stimulus is issued and popped when the
// DUT response is sampled. Build with +define+TIMER_PWM_EN to exercise PWM.
module tb_mpsoc_multi_timer;
    import mpsoc_timer_pkg::*;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;
    logic [NUM_CH-1:0] irq_vec;
    logic [NUM_CH-1:0] pwm_out;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] expv;

    mpsoc_multi_timer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_vec    (irq_vec),
        .pwm_out    (pwm_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic bus_write(input int ch, input logic [2:0] rg, input logic [31:0] data);
        @(negedge clk);
        address    = ADDR_W'((ch << 3) | int'(rg));
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = data;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input int ch, input logic [2:0] rg, output logic [31:0] data);
        @(negedge clk);
        address    = ADDR_W'((ch << 3) | int'(rg));
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        data       = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wait_irq(input int idx, input int budget, output int at_cyc, output bit seen);
        seen   = 1'b0;
        at_cyc = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (irq_vec[idx]) begin
                seen   = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        repeat (3) @(negedge clk);
        checks++; if (readdata !== 32'd0) begin errors++; $display("[TB] FAIL rst_readdata: got %0d expected 0", readdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL rst_irq: got %0b expected 0", irq); end
        checks++; if (pwm_out !== '0) begin errors++; $display("[TB] FAIL rst_pwm: got %b expected 0", pwm_out); end
        reset_n = 1'b1;
        exp_q.push_back(32'd49999); bus_read(0, REG_PERIOD, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL rst_period: got %0d expected %0d", got, expv); end
        exp_q.push_back(32'd0); bus_read(0, REG_STATUS, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL rst_status: got %0d expected %0d", got, expv); end
        exp_q.push_back(32'd0); bus_read(0, REG_CONTROL, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL rst_control: got %0d expected %0d", got, expv); end
        exp_q.push_back(32'd0); bus_read(0, 3'd6, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL rst_reserved: got %0d expected %0d", got, expv); end
    endtask

    task automatic test_periodic();
        int c0, t1, t2;
        bit seen;
        bus_write(1, REG_PERIOD, 32'd9);
        bus_write(1, REG_CONTROL, 32'h7);
        c0 = cyc;
        exp_q.push_back(32'd11);
        wait_irq(1, 40, t1, seen); expv = exp_q.pop_front();
        checks++; if (!seen || 32'(t1 - c0) !== expv) begin errors++; $display("[TB] FAIL ch1_first_to: got %0d (seen=%0b) expected %0d", t1 - c0, seen, expv); end
        checks++; if (irq !== 1'b1 || irq_vec !== 4'b0010) begin errors++; $display("[TB] FAIL ch1_irq: got irq=%0b vec=%b expected 1/0010", irq, irq_vec); end
        bus_write(1, REG_STATUS, 32'd0);
        checks++; if (irq_vec[1] !== 1'b0) begin errors++; $display("[TB] FAIL ch1_to_clear: got %0b expected 0", irq_vec[1]); end
        exp_q.push_back(32'd2); bus_read(1, REG_STATUS, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL ch1_status_run: got %0d expected %0d", got, expv); end
        exp_q.push_back(32'd10);
        wait_irq(1, 40, t2, seen); expv = exp_q.pop_front();
        checks++; if (!seen || 32'(t2 - t1) !== expv) begin errors++; $display("[TB] FAIL ch1_interval: got %0d (seen=%0b) expected %0d", t2 - t1, seen, expv); end
        bus_write(1, REG_CONTROL, 32'h8);
        bus_write(1, REG_STATUS, 32'd0);
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL ch1_stop_irq: got %0b expected 0", irq); end
    endtask

    task automatic test_one_shot();
        int c0, t;
        bit seen;
        bus_write(2, REG_PRESCALE, 32'h1234_0004);
        bus_write(2, REG_PERIOD, 32'd3);
        exp_q.push_back(32'd4); bus_read(2, REG_PRESCALE, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL ch2_prescale_trunc: got %0d expected %0d", got, expv); end
        bus_write(2, REG_CONTROL, 32'h5);
        c0 = cyc;
        exp_q.push_back(32'd21);
        wait_irq(2, 40, t, seen); expv = exp_q.pop_front();
        checks++; if (!seen || 32'(t - c0) !== expv) begin errors++; $display("[TB] FAIL ch2_timeout: got %0d (seen=%0b) expected %0d", t - c0, seen, expv); end
        exp_q.push_back(32'd1); bus_read(2, REG_STATUS, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL ch2_status: got %0d expected %0d", got, expv); end
        bus_write(2, REG_SNAP, 32'd0);
        exp_q.push_back(32'd3); bus_read(2, REG_SNAP, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL ch2_counter_hold: got %0d expected %0d", got, expv); end
        bus_write(2, REG_STATUS, 32'd0);
        wait_irq(2, 40, t, seen);
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL ch2_single: got %0b expected 0", seen); end
    endtask

    task automatic test_simultaneous();
        int c0;
        bus_write(2, REG_CONTROL, 32'hC);
        c0 = cyc;
        exp_q.push_back(32'd2); bus_read(2, REG_STATUS, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL sim_start_wins: got %0d expected %0d", got, expv); end
        exp_q.push_back(32'd0); bus_read(2, REG_CONTROL, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL sim_control_rb: got %0d expected %0d", got, expv); end
        for (int k = 0; k < 100 && cyc < c0 + 20; k++) @(negedge clk);
        address    = ADDR_W'((2 << 3) | int'(REG_STATUS));
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = 32'd0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        exp_q.push_back(32'd1); bus_read(2, REG_STATUS, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL sim_set_wins: got %0d expected %0d", got, expv); end
        checks++; if (irq_vec[2] !== 1'b0) begin errors++; $display("[TB] FAIL sim_ito_mask: got %0b expected 0", irq_vec[2]); end
        bus_write(2, REG_STATUS, 32'd0);
    endtask

    task automatic test_pwm();
        int highs, others;
        bus_write(3, REG_COMPARE, 32'd25);
        bus_write(3, REG_PERIOD, 32'd99);
        bus_write(3, REG_CONTROL, 32'h6);
`ifdef TIMER_PWM_EN
        exp_q.push_back(32'd25);
        exp_q.push_back(32'd50);
`else
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
`endif
        bus_read(3, REG_COMPARE, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL pwm_compare_rb: got %0d expected %0d", got, expv); end
        highs = 0; others = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (pwm_out[3] === 1'b1) highs++;
            if (pwm_out[2:0] !== 3'b000) others++;
        end
        expv = exp_q.pop_front();
        checks++; if (32'(highs) !== expv) begin errors++; $display("[TB] FAIL pwm_duty: got %0d expected %0d", highs, expv); end
        checks++; if (others !== 0) begin errors++; $display("[TB] FAIL pwm_other_ch: got %0d expected 0", others); end
        bus_write(3, REG_CONTROL, 32'h8);
        repeat (2) @(negedge clk);
        checks++; if (pwm_out !== '0) begin errors++; $display("[TB] FAIL pwm_stop: got %b expected 0", pwm_out); end
    endtask

    task automatic test_snap_period();
        int c0;
        bus_write(0, REG_CONTROL, 32'h6);
        c0 = cyc;
        for (int k = 0; k < 100 && cyc < c0 + 9; k++) @(negedge clk);
        address    = ADDR_W'(int'(REG_SNAP));
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = 32'd0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        exp_q.push_back(32'd49990); bus_read(0, REG_SNAP, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL ch0_snap: got %0d expected %0d", got, expv); end
        bus_write(0, REG_PERIOD, 32'd1234);
        bus_write(0, REG_SNAP, 32'd0);
        exp_q.push_back(32'd1234); bus_read(0, REG_SNAP, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL ch0_period_reload: got %0d expected %0d", got, expv); end
        exp_q.push_back(32'd0); bus_read(0, REG_STATUS, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL ch0_run_clear: got %0d expected %0d", got, expv); end
        exp_q.push_back(32'd1234); bus_read(0, REG_PERIOD, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL ch0_period_rb: got %0d expected %0d", got, expv); end
    endtask

    task automatic test_async_reset();
        bus_write(1, REG_CONTROL, 32'h7);
        repeat (15) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_irq: got %0b expected 1", irq); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (irq !== 1'b0 || readdata !== 32'd0) begin errors++; $display("[TB] FAIL arst_immediate: got irq=%0b rd=%0d expected 0/0", irq, readdata); end
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(32'd49999); bus_read(1, REG_PERIOD, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL arst_period: got %0d expected %0d", got, expv); end
        exp_q.push_back(32'd0); bus_read(1, REG_STATUS, got); expv = exp_q.pop_front();
        checks++; if (got !== expv) begin errors++; $display("[TB] FAIL arst_status: got %0d expected %0d", got, expv); end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_one_shot();
        test_simultaneous();
        test_pwm();
        test_snap_period();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
